// File: rtl/psum_accumulator_pkg.sv
// Shared widths, saturation limits and FSM encodings for the partial-sum
// accumulation path.
package psum_accumulator_pkg;

   localparam int unsigned PSUM_WID = 32;
   localparam int unsigned CNT_WID  = 8;

   localparam logic [PSUM_WID-1:0] PSUM_MAX = {1'b0, {(PSUM_WID-1){1'b1}}};
   localparam logic [PSUM_WID-1:0] PSUM_MIN = {1'b1, {(PSUM_WID-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/psum_accumulator_if.sv
// Control, partial-sum stream and result strobe between the PE array,
// the accumulator and the pooling stage.
interface psum_accumulator_if
   import psum_accumulator_pkg::*;
#(
   parameter int unsigned PSUM_W = PSUM_WID,
   parameter int unsigned CNT_W  = CNT_WID
);
   logic              start;
   logic [CNT_W-1:0]  cfg_num_out;
   logic              in_valid;
   logic              in_ready;
   logic [PSUM_W-1:0] in_psum;
   logic              in_last;
   logic              out_valid;
   logic [PSUM_W-1:0] out_data;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_clear;
   logic              done;
   logic              busy;
   logic              ovf;

   modport master (
      output start, cfg_num_out, in_valid, in_psum, in_last,
      input  in_ready, out_valid, out_data, out_cnt, out_clear, done, busy, ovf
   );

   modport slave (
      input  start, cfg_num_out, in_valid, in_psum, in_last,
      output in_ready, out_valid, out_data, out_cnt, out_clear, done, busy, ovf
   );
endinterface

// File: rtl/psum_accumulator_sat_add_signed.sv
// Combinational two's-complement add with clamp to the signed W-bit range;
// ovf_o flags that the clamp was applied.
module sat_add_signed
   import psum_accumulator_pkg::*;
#(
   parameter int unsigned W = PSUM_WID
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);
   logic [W:0] wide;

   always_comb begin
      wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
      ovf_o = wide[W] ^ wide[W-1];
      if (!ovf_o)
         sum_o = wide[W-1:0];
      else if (wide[W])
         sum_o = {1'b1, {(W-1){1'b0}}};
      else
         sum_o = {1'b0, {(W-1){1'b1}}};
   end
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates tiled partial sums per output neuron into a saturated result
// and strobes it, with its neuron index, to the pooling stage.
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int unsigned PSUM_W = PSUM_WID,
   parameter int unsigned CNT_W  = CNT_WID
) (
   input logic               clk,
   input logic               rst,
   psum_accumulator_if.slave bus
);
   state_e            state_q, state_d;
   logic [PSUM_W-1:0] acc_q, result_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, num_q, out_cnt_q;
   logic              in_ready_q, out_valid_q, out_clear_q, done_q, busy_q, ovf_q;
   logic              sat_d, xfer;

   sat_add_signed #(.W(PSUM_W)) u_sat (
      .a_i   (acc_q),
      .b_i   (bus.in_psum),
      .sum_o (sum_d),
      .ovf_o (sat_d)
   );

   assign xfer = bus.in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
         ST_CLEAR: state_d = (num_q == '0) ? ST_DONE : ST_ACCUM;
         ST_ACCUM: if (xfer && bus.in_last) state_d = ST_EMIT;
         ST_EMIT:  state_d = (cnt_q == num_q - CNT_W'(1)) ? ST_DONE : ST_ACCUM;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state, so each one lines up
   // with the cycle its state is occupied; result_q reads 0 outside EMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         num_q       <= '0;
         out_cnt_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_clear_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d == ST_ACCUM);
         out_valid_q <= (state_d == ST_EMIT);
         out_clear_q <= (state_d == ST_CLEAR);
         done_q      <= (state_d == ST_DONE);
         busy_q      <= (state_d != ST_IDLE);
         out_cnt_q   <= (state_d == ST_EMIT) ? cnt_q : '0;
         result_q    <= '0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  num_q <= bus.cfg_num_out;
                  ovf_q <= 1'b0;
               end
            end
            ST_CLEAR: begin
               acc_q <= '0;
               cnt_q <= '0;
            end
            ST_ACCUM: begin
               if (xfer) begin
                  ovf_q <= ovf_q | sat_d;
                  if (bus.in_last) begin
                     result_q <= sum_d;
                     acc_q    <= '0;
                  end else begin
                     acc_q    <= sum_d;
                  end
               end
            end
            ST_EMIT: cnt_q <= cnt_q + CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = result_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.out_clear = out_clear_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.ovf       = ovf_q;
endmodule
